md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers, in the E stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo.
- Provides HI/LO to the E-stage result mux for mfhi/mflo.
- Produces busy/pending status. The D-stage hazard/stall unit consumes this status to hold any md-class instruction in D until the unit is free.

---
 rtl/md_unit_pkg.sv | 33 +++
 rtl/md_core.sv | 60 ++++++
 rtl/md_unit.sv | 109 ++++++++++
 tb/tb_md_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type and default busy-cycle counts.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_CNT_W            = 4;
    localparam int MD_MULT_CYCLES_DEF  = 5;
    localparam int MD_DIV_CYCLES_DEF   = 10;

    function automatic logic md_is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational result generator: 64-bit product, or quotient (lo) and
// remainder (hi) including the divide-by-zero and signed-overflow cases.
module md_core
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        is_signed;

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);

        // Sign-extending to 64 bits lets one unsigned multiplier serve both forms.
        a_ext   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        product = a_ext * b_ext;

        a_mag  = (is_signed && a[31]) ? (32'd0 - a) : a;
        b_mag  = (is_signed && b[31]) ? (32'd0 - b) : b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;

        hi_res = 32'd0;
        lo_res = 32'd0;
        if (md_is_mult(op)) begin
            hi_res = product[63:32];
            lo_res = product[31:0];
        end else if (md_is_div(op)) begin
            if (b == 32'd0) begin
                hi_res = a;
                lo_res = 32'hFFFF_FFFF;
            end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                hi_res = 32'd0;
                lo_res = 32'h8000_0000;
            end else if (is_signed) begin
                // Quotient truncates toward zero; remainder follows the dividend.
                lo_res = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
                hi_res = a[31] ? (32'd0 - r_mag) : r_mag;
            end else begin
                lo_res = q_mag;
                hi_res = r_mag;
            end
        end
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, busy FSM and cycle counter.
// Results are computed at issue into shadow registers and committed when busy ends.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        pending
);

    localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_CYCLES);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   count_q, count_d;
    logic [31:0]           hi_q, hi_d;
    logic [31:0]           lo_q, lo_d;
    logic [31:0]           hi_s_q, hi_s_d;
    logic [31:0]           lo_s_q, lo_s_d;
    logic                  busy_q, busy_d;
    logic [31:0]           core_hi;
    logic [31:0]           core_lo;

    md_core u_core (
        .op     (md_op),
        .a      (a),
        .b      (b),
        .hi_res (core_hi),
        .lo_res (core_lo)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_s_d  = hi_s_q;
        lo_s_d  = lo_s_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (md_is_mult(md_op) || md_is_div(md_op)) begin
                        hi_s_d  = core_hi;
                        lo_s_d  = core_lo;
                        count_d = md_is_mult(md_op) ? MULT_CNT : DIV_CNT;
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = a;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                // Any start arriving here is dropped; the stall unit should prevent it.
                count_d = count_q - 1'b1;
                if (count_q == MD_CNT_W'(1)) begin
                    hi_d    = hi_s_q;
                    lo_d    = lo_s_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_s_q  <= '0;
            lo_s_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_s_q  <= hi_s_d;
            lo_s_q  <= lo_s_d;
            busy_q  <= busy_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = busy_q;
    assign pending = start || busy_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of mult/div results plus
// hand-written mthi/mtlo, start-while-busy and mid-operation reset sequences.
module tb_md_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        pending;

    int tests_run;
    int tests_failed;

    // Expected architectural HI/LO, maintained by the bench alone.
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[10];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .pending (pending)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Issue one mult/div and follow it to commit, checking busy length and HI/LO.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi,
                         input logic [31:0] elo, input int ncyc);
        int nb;
        @(negedge clk);
        check({nm, " idle_before"}, {31'd0, busy}, 32'd0);
        start = 1'b1;
        md_op = op;
        a     = va;
        b     = vb;
        #1;
        check({nm, " pending_on_start"}, {31'd0, pending}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        nb    = 0;
        while (busy === 1'b1 && nb < 40) begin
            if (hi !== model_hi || lo !== model_lo) begin
                check({nm, " hi_held"}, hi, model_hi);
                check({nm, " lo_held"}, lo, model_lo);
            end
            nb++;
            @(negedge clk);
        end
        check({nm, " busy_cycles"}, 32'(nb), 32'(ncyc));
        check({nm, " hi"}, hi, ehi);
        check({nm, " lo"}, lo, elo);
        model_hi = ehi;
        model_lo = elo;
    endtask

    initial begin
        int nb;
        tests_run    = 0;
        tests_failed = 0;
        model_hi     = 32'd0;
        model_lo     = 32'd0;
        start        = 1'b0;
        md_op        = 3'd0;
        a            = 32'd0;
        b            = 32'd0;
        reset_n      = 1'b0;

        vecs[0] = '{"mult_neg2x3",   3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{"multu_max_x2",  3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{"div_m7_2",      3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{"divu_m7_2",     3'd3, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 10};
        vecs[4] = '{"div_5_0",       3'd2, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 10};
        vecs[5] = '{"div_ovf",       3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[6] = '{"divu_5_0",      3'd3, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 10};
        vecs[7] = '{"mult_7_m3",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[8] = '{"div_7_m2",      3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[9] = '{"div_m7_m2",     3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst pending", {31'd0, pending}, 32'd0);
        reset_n = 1'b1;

        // Table-driven mult/div vectors
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].va, vecs[i].vb,
                  vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cycles);
        end

        // mthi then mtlo back to back; no busy, pending tracks start
        @(negedge clk);
        start = 1'b1; md_op = 3'd4; a = 32'h1234;
        #1;
        check("mthi pending", {31'd0, pending}, 32'd1);
        @(negedge clk);
        check("mthi hi", hi, 32'h1234);
        check("mthi busy", {31'd0, busy}, 32'd0);
        md_op = 3'd5; a = 32'h5678;
        #1;
        check("mtlo pending", {31'd0, pending}, 32'd1);
        @(negedge clk);
        start = 1'b0; a = 32'd0;
        #1;
        check("mtlo lo", lo, 32'h5678);
        check("mtlo hi_kept", hi, 32'h1234);
        check("mtlo busy", {31'd0, busy}, 32'd0);
        check("mtlo pending_low", {31'd0, pending}, 32'd0);
        model_hi = 32'h1234;
        model_lo = 32'h5678;

        // Reserved op is a no-op
        @(negedge clk);
        start = 1'b1; md_op = 3'd6; a = 32'hDEAD_BEEF; b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        check("rsv hi", hi, model_hi);
        check("rsv lo", lo, model_lo);
        check("rsv busy", {31'd0, busy}, 32'd0);

        // Start while busy (mult and mthi) is ignored; div 100/7 commits on schedule
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            if (nb == 2) begin
                start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
                #1;
                check("intrude pending", {31'd0, pending}, 32'd1);
            end else if (nb == 4) begin
                start = 1'b1; md_op = 3'd4; a = 32'hFFFF;
            end else begin
                start = 1'b0;
            end
            nb++;
            @(negedge clk);
        end
        start = 1'b0;
        check("intrude busy_cycles", 32'(nb), 32'd10);
        check("intrude hi", hi, 32'd2);
        check("intrude lo", lo, 32'd14);
        @(negedge clk);
        check("intrude busy_after", {31'd0, busy}, 32'd0);
        check("intrude hi_after", hi, 32'd2);
        model_hi = 32'd2;
        model_lo = 32'd14;

        // Reset in cycle 3 of a div aborts it immediately
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        repeat (12) @(negedge clk);
        check("midrst no_commit_hi", hi, 32'd0);
        check("midrst no_commit_lo", lo, 32'd0);
        do_op("post_rst_mult", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
